// File: rtl/mouse_irq_reader_pkg.sv
// Shared definitions for the mouse interrupt reader and the mouse peripheral's
// address decode.
//   state_t           : reader FSM encoding (IDLE, ACK, READ, PUBLISH)
//   DEFAULT_BASE_ADDR : first of the three peripheral read registers
//   DEFAULT_IDLE_ADDR : parking address that decodes to no peripheral
//   REG_STATUS/DX/DY  : register offsets from the base address
//   reg_addr()        : 8-bit modulo address of a register offset
package mouse_irq_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        READ    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hA0;
    localparam logic [7:0] DEFAULT_IDLE_ADDR = 8'hFF;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DX     = 2'd1;
    localparam logic [1:0] REG_DY     = 2'd2;

    // Wraps at 8 bits, so a base near the top of the map rolls over to 00.
    function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [1:0] idx);
        return base + {6'b0, idx};
    endfunction

endpackage

// File: rtl/mouse_irq_reader_sat_counter.sv
// Event counter with selectable overflow behaviour.
//   CLK   : clock
//   RESET : synchronous, active-high; clears COUNT
//   INC   : count one event this cycle
//   COUNT : current count; sticks at all-ones when SATURATE=1, else wraps to 0
module sat_counter #(
    parameter int       WIDTH    = 8,
    parameter bit       SATURATE = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (INC) begin
            if (!(SATURATE && (&COUNT))) begin
                COUNT <= COUNT + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mouse_irq_reader.sv
// Bus initiator that services the mouse peripheral's interrupt on its own:
// acknowledge, read STATUS/DX/DY from three consecutive registers, then publish
// the bytes together with a one-cycle SAMPLE_VALID strobe.
//   CLK, RESET           : clock, synchronous active-high reset
//   ENABLE               : servicing allowed (looked at only when idle)
//   BUS_INTERRUPT_RAISE  : level interrupt from the peripheral
//   BUS_INTERRUPT_ACK    : one-cycle acknowledge pulse
//   BUS_WE, BUS_ADDR     : read-only initiator bus (WE tied low)
//   BUS_DATA             : shared data bus, never driven here, sampled only
//   MOUSE_STATUS/DX/DY   : last complete sample
//   SAMPLE_VALID         : high in the cycle new MOUSE_* values first appear
//   SAMPLE_COUNT         : completed transactions (wrapping)
//   LATE_COUNT           : interrupt rising edges seen while busy (saturating)
module mouse_irq_reader
    import mouse_irq_reader_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter logic [7:0] IDLE_ADDR    = DEFAULT_IDLE_ADDR,
    parameter int         READ_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        BUS_INTERRUPT_RAISE,
    output logic        BUS_INTERRUPT_ACK,
    output logic        BUS_WE,
    output logic [7:0]  BUS_ADDR,
    inout  wire  [7:0]  BUS_DATA,
    output logic [7:0]  MOUSE_STATUS,
    output logic [7:0]  MOUSE_DX,
    output logic [7:0]  MOUSE_DY,
    output logic        SAMPLE_VALID,
    output logic [15:0] SAMPLE_COUNT,
    output logic [7:0]  LATE_COUNT
);

    localparam int                WAIT_W    = $clog2(READ_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

    state_t             state;
    state_t             next_state;
    logic [1:0]         idx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [7:0]         shadow_status;
    logic [7:0]         shadow_dx;
    logic               raise_d;
    logic               start;
    logic               last_beat;
    logic               publish_now;
    logic               late_edge;

    assign BUS_DATA = 8'hZZ;
    assign BUS_WE   = 1'b0;

    assign start       = BUS_INTERRUPT_RAISE && ENABLE;
    assign last_beat   = (state == READ) && (wait_cnt == WAIT_LAST);
    assign publish_now = last_beat && (idx == REG_DY);
    assign late_edge   = BUS_INTERRUPT_RAISE && !raise_d && (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // PUBLISH is the hand-back to idle: it applies the idle start test itself so
    // a still-pending interrupt is acknowledged on the very next edge, giving
    // back-to-back transactions every 3*READ_LATENCY+2 cycles.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACK;
            ACK:     next_state = READ;
            READ:    if (publish_now) next_state = PUBLISH;
            PUBLISH: next_state = start ? ACK : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ACK/VALID are registered copies of the state being entered, so they are
    // high exactly while the FSM sits in ACK/PUBLISH.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUS_INTERRUPT_ACK <= 1'b0;
            SAMPLE_VALID      <= 1'b0;
            BUS_ADDR          <= IDLE_ADDR;
            idx               <= REG_STATUS;
            wait_cnt          <= '0;
            shadow_status     <= 8'h00;
            shadow_dx         <= 8'h00;
            MOUSE_STATUS      <= 8'h00;
            MOUSE_DX          <= 8'h00;
            MOUSE_DY          <= 8'h00;
            raise_d           <= 1'b0;
        end else begin
            BUS_INTERRUPT_ACK <= (next_state == ACK);
            SAMPLE_VALID      <= (next_state == PUBLISH);
            raise_d           <= BUS_INTERRUPT_RAISE;
            case (state)
                ACK: begin
                    idx      <= REG_STATUS;
                    wait_cnt <= '0;
                    BUS_ADDR <= reg_addr(BASE_ADDR, REG_STATUS);
                end
                READ: begin
                    if (!last_beat) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end else if (idx != REG_DY) begin
                        if (idx == REG_STATUS) shadow_status <= BUS_DATA;
                        else                   shadow_dx     <= BUS_DATA;
                        idx      <= idx + 2'd1;
                        wait_cnt <= '0;
                        BUS_ADDR <= reg_addr(BASE_ADDR, idx + 2'd1);
                    end else begin
                        // The DY byte goes straight into its output register so
                        // all three bytes land in the same cycle as SAMPLE_VALID.
                        MOUSE_STATUS <= shadow_status;
                        MOUSE_DX     <= shadow_dx;
                        MOUSE_DY     <= BUS_DATA;
                        BUS_ADDR     <= IDLE_ADDR;
                    end
                end
                default: BUS_ADDR <= IDLE_ADDR;
            endcase
        end
    end

    sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_sample_count (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (publish_now),
        .COUNT (SAMPLE_COUNT)
    );

    sat_counter #(.WIDTH(8), .SATURATE(1'b1)) u_late_count (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (late_edge),
        .COUNT (LATE_COUNT)
    );

endmodule

// File: tb/tb_mouse_irq_reader.sv
module tb_mouse_irq_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        raise = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        sel = 1'b0;

    logic        ack_a, we_a, valid_a, ack_b, we_b, valid_b;
    logic [7:0]  addr_a, st_a, dx_a, dy_a, late_a, addr_b, st_b, dx_b, dy_b, late_b;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  per_a, per_b;
    wire  [7:0]  bus_data_a;
    wire  [7:0]  bus_data_b;

    logic [7:0]  mem [256];

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    // Peripheral model: register contents appear one cycle after the address.
    always @(posedge clk) begin
        per_a <= mem[addr_a];
        per_b <= mem[addr_b];
    end
    assign bus_data_a = per_a;
    assign bus_data_b = per_b;

    mouse_irq_reader dut_a (
        .CLK(clk), .RESET(rst), .ENABLE(en_a), .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK(ack_a), .BUS_WE(we_a), .BUS_ADDR(addr_a), .BUS_DATA(bus_data_a),
        .MOUSE_STATUS(st_a), .MOUSE_DX(dx_a), .MOUSE_DY(dy_a), .SAMPLE_VALID(valid_a),
        .SAMPLE_COUNT(cnt_a), .LATE_COUNT(late_a)
    );

    mouse_irq_reader #(.BASE_ADDR(8'hFE), .IDLE_ADDR(8'hFF), .READ_LATENCY(3)) dut_b (
        .CLK(clk), .RESET(rst), .ENABLE(en_b), .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK(ack_b), .BUS_WE(we_b), .BUS_ADDR(addr_b), .BUS_DATA(bus_data_b),
        .MOUSE_STATUS(st_b), .MOUSE_DX(dx_b), .MOUSE_DY(dy_b), .SAMPLE_VALID(valid_b),
        .SAMPLE_COUNT(cnt_b), .LATE_COUNT(late_b)
    );

    logic        o_ack, o_we, o_valid;
    logic [7:0]  o_addr, o_st, o_dx, o_dy, o_late;
    logic [15:0] o_cnt;
    assign o_ack   = sel ? ack_b   : ack_a;
    assign o_we    = sel ? we_b    : we_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_st    = sel ? st_b    : st_a;
    assign o_dx    = sel ? dx_b    : dx_a;
    assign o_dy    = sel ? dy_b    : dy_a;
    assign o_late  = sel ? late_b  : late_a;
    assign o_cnt   = sel ? cnt_b   : cnt_a;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic wait_ack(input int bound);
        int n = 0;
        step();
        while (!o_ack && n < bound) begin
            step();
            n++;
        end
        chk("ack_seen", 16'(o_ack), 16'd1);
    endtask

    // Called in the ACK cycle; walks the expected address schedule and ends in
    // the publish cycle. raise_up_at raises the interrupt in that cycle.
    task automatic check_txn(input int rl, input logic [7:0] base,
                             input logic [7:0] es, input logic [7:0] edx, input logic [7:0] edy,
                             input logic [15:0] ecnt, input logic [7:0] elate,
                             input int raise_up_at);
        logic [7:0] ea;
        chk("ack_cycle_addr", 16'(o_addr), 16'h00FF);
        for (int c = 1; c <= 3 * rl; c++) begin
            step();
            if (c == raise_up_at) raise = 1'b1;
            ea = base + 8'((c - 1) / rl);
            chk("read_addr", 16'(o_addr), 16'(ea));
            chk("read_we", 16'(o_we), 16'd0);
            chk("read_valid", 16'(o_valid), 16'd0);
            if (c == 1) chk("ack_single_pulse", 16'(o_ack), 16'd0);
        end
        step();
        chk("pub_valid", 16'(o_valid), 16'd1);
        chk("pub_addr", 16'(o_addr), 16'h00FF);
        chk("pub_status", 16'(o_st), 16'(es));
        chk("pub_dx", 16'(o_dx), 16'(edx));
        chk("pub_dy", 16'(o_dy), 16'(edy));
        chk("pub_count", o_cnt, ecnt);
        chk("pub_late", 16'(o_late), 16'(elate));
    endtask

    initial begin
        logic [7:0] s0, s1, s2;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        chk("rst_addr", 16'(addr_a), 16'h00FF);
        chk("rst_ack", 16'(ack_a), 16'd0);
        chk("rst_valid", 16'(valid_a), 16'd0);
        chk("rst_we", 16'(we_a), 16'd0);
        chk("rst_out", {st_a, dx_a | dy_a}, 16'd0);
        chk("rst_cnt", cnt_a, 16'd0);
        chk("rst_late", 16'(late_a), 16'd0);

        // Single transaction, peripheral returns its own address
        rst = 1'b0;
        en_a = 1'b1;
        raise = 1'b1;
        wait_ack(4);
        raise = 1'b0;
        exp_cnt++;
        check_txn(2, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 16'(exp_cnt), 8'd0, -1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stable_valid", 16'(valid_a), 16'd0);
            chk("stable_ack", 16'(ack_a), 16'd0);
            chk("stable_out", {st_a, dy_a}, 16'hA0A2);
        end

        // RAISE held: back-to-back every 8 cycles, 5 samples in 40 cycles
        do_reset();
        rand_mem();
        raise = 1'b1;
        wait_ack(4);
        for (int t = 0; t < 5; t++) begin
            exp_cnt++;
            check_txn(2, 8'hA0, mem[8'hA0], mem[8'hA1], mem[8'hA2], 16'(exp_cnt), 8'd0, -1);
            if (t == 4) raise = 1'b0;
            step();
            chk("b2b_ack", 16'(ack_a), (t == 4) ? 16'd0 : 16'd1);
        end
        chk("b2b_count5", cnt_a, 16'd5);

        // Late edge during READ of idx 1, second transaction right after PUBLISH
        do_reset();
        rand_mem();
        raise = 1'b1;
        wait_ack(4);
        raise = 1'b0;
        exp_cnt++;
        check_txn(2, 8'hA0, mem[8'hA0], mem[8'hA1], mem[8'hA2], 16'(exp_cnt), 8'd1, 3);
        step();
        chk("late_restart_ack", 16'(ack_a), 16'd1);
        raise = 1'b0;
        exp_cnt++;
        check_txn(2, 8'hA0, mem[8'hA0], mem[8'hA1], mem[8'hA2], 16'(exp_cnt), 8'd1, -1);

        // Many late edges: counter must stick at FF
        for (int k = 0; k < 1300; k++) begin
            raise = ~raise;
            step();
        end
        raise = 1'b0;
        repeat (12) step();
        chk("late_saturate", 16'(late_a), 16'h00FF);

        // Reset in cycle 4 of a transaction aborts it
        rand_mem();
        raise = 1'b1;
        wait_ack(4);
        raise = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_addr", 16'(addr_a), 16'h00FF);
        chk("abort_out", {st_a, dx_a | dy_a}, 16'd0);
        chk("abort_cnt", cnt_a, 16'd0);
        chk("abort_late", 16'(late_a), 16'd0);
        for (int k = 0; k < 10; k++) begin
            chk("abort_valid", 16'(valid_a), 16'd0);
            chk("abort_ack", 16'(ack_a), 16'd0);
            chk("abort_idle_addr", 16'(addr_a), 16'h00FF);
            step();
        end
        exp_cnt = 0;
        rand_mem();
        raise = 1'b1;
        wait_ack(4);
        raise = 1'b0;
        exp_cnt++;
        check_txn(2, 8'hA0, mem[8'hA0], mem[8'hA1], mem[8'hA2], 16'(exp_cnt), 8'd0, -1);

        // ENABLE low blocks servicing; one enabled cycle runs a full transaction
        step();
        en_a = 1'b0;
        rand_mem();
        raise = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("dis_ack", 16'(ack_a), 16'd0);
            chk("dis_addr", 16'(addr_a), 16'h00FF);
        end
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        raise = 1'b0;
        chk("en_pulse_ack", 16'(ack_a), 16'd1);
        exp_cnt++;
        check_txn(2, 8'hA0, mem[8'hA0], mem[8'hA1], mem[8'hA2], 16'(exp_cnt), 8'd0, -1);

        // Wrapping base, longer latency
        step();
        sel = 1'b1;
        rand_mem();
        s0 = mem[8'hFE];
        s1 = mem[8'hFF];
        s2 = mem[8'h00];
        raise = 1'b1;
        en_b = 1'b1;
        wait_ack(4);
        raise = 1'b0;
        en_b = 1'b0;
        check_txn(3, 8'hFE, s0, s1, s2, 16'd1, 8'd0, -1);
        step();
        chk("wrap_valid_drop", 16'(valid_b), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mouse_irq_reader.md
Name: mouse_irq_reader

Overview:
- Bus-initiator side of the mouse peripheral interface: services the peripheral's interrupt without the CPU.
- On an interrupt it acknowledges, then runs three back-to-back bus reads at BASE_ADDR+0..2.
- Publishes the captured bytes as status/dX/dY, with a one-cycle valid strobe.
- Sits between the mouse bus peripheral and the display/control logic; it is the only bus initiator on its segment.

Parameters:
- BASE_ADDR, 8'hA0, address of the first of three consecutive read registers.
- IDLE_ADDR, 8'hFF, address driven when not reading; must not decode to any peripheral.
- READ_LATENCY, 2, cycles each address is held; data is sampled on the last of these edges. Must be 2 or more.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  servicing allowed when high
- BUS_INTERRUPT_RAISE  in  1  level interrupt from the peripheral
- BUS_INTERRUPT_ACK  out  1  one-cycle acknowledge pulse
- BUS_WE  out  1  always 0 (read-only initiator)
- BUS_ADDR  out  8  bus address
- BUS_DATA  inout  8  never driven by this block (constant 8'hZZ); sampled only
- MOUSE_STATUS  out  8  byte read from BASE_ADDR
- MOUSE_DX  out  8  byte read from BASE_ADDR+1
- MOUSE_DY  out  8  byte read from BASE_ADDR+2
- SAMPLE_VALID  out  1  one-cycle pulse when the three outputs update
- SAMPLE_COUNT  out  16  completed transactions, wraps at 16'hFFFF to 0
- LATE_COUNT  out  8  RAISE rising edges seen while busy; saturates at 8'hFF

Behaviour:
- Clock CLK. Reset RESET is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - BUS_ADDR = IDLE_ADDR.
  - ACK = 0, SAMPLE_VALID = 0, BUS_WE = 0.
  - MOUSE_* = 0, counters = 0, shadow registers = 0, state = IDLE.
- RESET asserted mid-transaction aborts it immediately. No publish, no ACK.
- FSM states: IDLE, ACK, READ, PUBLISH.
  - IDLE: if RAISE && ENABLE, go to ACK. BUS_ADDR = IDLE_ADDR.
  - ACK: BUS_INTERRUPT_ACK = 1 for this single cycle. Next state READ with idx = 0, wait = 0, BUS_ADDR = BASE_ADDR.
  - READ: hold BUS_ADDR = BASE_ADDR + idx for READ_LATENCY cycles.
    - On the edge ending the last cycle, capture BUS_DATA into shadow[idx].
    - If idx < 2: increment idx, set BUS_ADDR to the next address (no idle gap).
    - Otherwise go to PUBLISH.
  - PUBLISH: single cycle.
    - MOUSE_STATUS/DX/DY take shadow[0..2] simultaneously.
    - SAMPLE_VALID = 1 in the same cycle the new values first appear.
    - SAMPLE_COUNT += 1. BUS_ADDR returns to IDLE_ADDR.
    - Next state IDLE.
- Latency with READ_LATENCY = 2:
  - ACK high in cycle 0.
  - Addresses A0/A1/A2 are driven in cycles 1-2, 3-4, 5-6.
  - SAMPLE_VALID is high in cycle 7.
  - A new ACK can occur no earlier than cycle 8.
- Address arithmetic is 8-bit modulo: BASE_ADDR 8'hFE reads FE, FF, 00.
- MOUSE_* outputs are stable between publishes. A partial transaction never reaches the outputs.
- ENABLE:
  - Sampled only in IDLE.
  - Deasserting it mid-transaction does not abort; the transaction completes and publishes.
- RAISE handling:
  - RAISE is a level input.
  - If RAISE is still or again high on return to IDLE, a new transaction starts on the next edge.
  - LATE_COUNT increments when RAISE is 0 in the previous cycle and 1 in the current cycle while state != IDLE.
  - A RAISE-high cycle coinciding with ACK is not a late edge unless RAISE was low in the previous cycle.
- BUS_DATA value X/Z outside capture edges is ignored.

Decomposition:
- Shared package:
  - State encoding (2-bit enum: IDLE, ACK, READ, PUBLISH).
  - Default BASE_ADDR and IDLE_ADDR constants, shared with the peripheral's address decode.
  - Register index constants (STATUS = 0, DX = 1, DY = 2).
- One natural sub-module: sat_counter, a parameterised width counter with saturate/wrap select.
  - Used for LATE_COUNT (saturating) and SAMPLE_COUNT (wrapping).
- FSM, address generation and shadow capture remain in the top module.

Test Plan:
- Bench peripheral returns 8'hA0/8'hA1/8'hA2 one cycle after the address; assert RAISE with ENABLE = 1.
  - Required: ACK is a single pulse.
  - Required: BUS_ADDR sequence FF, A0, A0, A1, A1, A2, A2, FF.
  - Required: MOUSE_STATUS/DX/DY = A0/A1/A2 with SAMPLE_VALID high exactly 7 cycles after ACK; SAMPLE_COUNT = 1.
- RAISE held high continuously.
  - Required: back-to-back transactions 8 cycles apart; SAMPLE_COUNT = 5 after 40 cycles; BUS_WE stays 0 throughout.
- RAISE pulses low-then-high during READ of idx 1.
  - Required: LATE_COUNT = 1; second transaction starts on the edge after PUBLISH.
  - Stress: force 300 late edges; required: LATE_COUNT saturates at 8'hFF.
- RESET asserted in cycle 4 of a transaction.
  - Required: BUS_ADDR = FF, outputs = 0, SAMPLE_VALID never pulses, state IDLE.
  - Required: the next RAISE yields a full correct transaction.
- ENABLE = 0 with RAISE high.
  - Required: no ACK and BUS_ADDR stays FF.
  - Then ENABLE = 1 for one cycle and 0 after: required: transaction runs to completion and publishes.
- Parameter case BASE_ADDR = 8'hFE, READ_LATENCY = 3.
  - Required: addresses FE×3, FF×3, 00×3; SAMPLE_VALID 10 cycles after ACK.
